// File: rtl/fir_pkg.sv
// fir_pkg: defaults shared by the FIR filter instance and its output stage,
// plus a constant-evaluable clog2 used to size FIFO pointers and level ports.
package fir_pkg;

    localparam int WW_DATA_DEF    = 8;  // sample width, matches the filter's output width
    localparam int LATENCY_FIR    = 3;  // i_en to o_data: prod_d, sum_d, sum3_d stages
    localparam int DECIM_W_DEF    = 4;  // width of the runtime decimation factor
    localparam int FIFO_DEPTH_DEF = 8;  // output FIFO entries (power of 2, >= 2)

    // Ceiling log2; clog2(1) = 0. Usable in parameter and port-width expressions.
    function automatic int clog2(input int value);
        int res;
        res = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            res++;
        end
        return res;
    endfunction

endpackage

// File: rtl/fir_out_fifo.sv
// fir_out_fifo: synchronous FIFO with a registered head (no fall-through).
// A word written into an empty FIFO appears on o_rd_data / !o_empty on the
// cycle after the write. Simultaneous read and write are allowed when full.
//
// Ports:
//   clk        rising-edge clock
//   i_rst      asynchronous active-high reset (pointers, level, head -> 0)
//   i_srst     synchronous clear, priority over read and write
//   i_wr       write request (ignored when full unless a read happens too)
//   i_wr_data  write data
//   i_rd       read request (ignored when empty)
//   o_rd_data  head word, held until it is read
//   o_level    occupancy 0..DEPTH
//   o_full     level == DEPTH
//   o_empty    level == 0
module fir_out_fifo
    import fir_pkg::*;
#(
    parameter int WIDTH = WW_DATA_DEF,
    parameter int DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                   clk,
    input  logic                   i_rst,
    input  logic                   i_srst,
    input  logic                   i_wr,
    input  logic [WIDTH-1:0]       i_wr_data,
    input  logic                   i_rd,
    output logic [WIDTH-1:0]       o_rd_data,
    output logic [clog2(DEPTH):0]  o_level,
    output logic                   o_full,
    output logic                   o_empty
);

    localparam int AW = clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] LEVEL_FULL = LW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             wr_ok, rd_ok;

    assign o_full  = (level_q == LEVEL_FULL);
    assign o_empty = (level_q == '0);
    assign rd_ok   = i_rd && !o_empty;
    // A read in the same cycle frees the slot, so a write into a full FIFO is legal then.
    assign wr_ok   = i_wr && (!o_full || rd_ok);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves it unassigned and no latch is inferred.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        head_d   = head_q;
        if (i_srst) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            head_d   = '0;
        end else begin
            if (wr_ok) wr_ptr_d = wr_ptr_q + AW'(1);
            if (rd_ok) rd_ptr_d = rd_ptr_q + AW'(1);
            case ({wr_ok, rd_ok})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
            // Preload the head register with whatever will be at the front next cycle.
            // The word being written this cycle is not in mem_q yet, so bypass it.
            if (level_d != '0) begin
                if (wr_ok && (wr_ptr_q == rd_ptr_d)) head_d = i_wr_data;
                else                                 head_d = mem_q[rd_ptr_d];
            end
        end
    end

    always_ff @(posedge clk or posedge i_rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            head_q   <= head_d;
        end
    end

    // NOTE: storage is deliberately not reset; level/pointers define which entries are meaningful,
    // and leaving the array reset-free lets it map onto plain RAM/flops without reset fan-out.
    always_ff @(posedge clk) begin
        if (wr_ok && !i_srst) mem_q[wr_ptr_q] <= i_wr_data;
    end

    assign o_rd_data = head_q;
    assign o_level   = level_q;

endmodule

// File: rtl/fir_decim_out.sv
// fir_decim_out: output stage behind the FIR filter. A shift register models
// the filter latency to know when i_data is a real response, a counter keeps
// one sample in every N, and kept samples are queued in fir_out_fifo and
// offered on a valid/ready stream.
//
// Ports:
//   clk         rising-edge clock
//   i_rst       asynchronous active-high reset
//   i_srst      synchronous clear (same signal as the filter's), highest priority
//   i_en        sample strobe (same signal as the filter's i_en)
//   i_decim     decimation factor N; 0 and 1 keep every sample
//   i_data      filter output sample
//   o_data      FIFO head sample
//   o_valid     o_data is valid
//   i_ready     consumer accepts o_data
//   o_level     FIFO occupancy
//   o_overflow  sticky: a kept sample was dropped on a full FIFO
module fir_decim_out
    import fir_pkg::*;
#(
    parameter int WW_DATA    = WW_DATA_DEF,
    parameter int LATENCY    = LATENCY_FIR,
    parameter int DECIM_W    = DECIM_W_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                          clk,
    input  logic                          i_rst,
    input  logic                          i_srst,
    input  logic                          i_en,
    input  logic [DECIM_W-1:0]            i_decim,
    input  logic signed [WW_DATA-1:0]     i_data,
    output logic signed [WW_DATA-1:0]     o_data,
    output logic                          o_valid,
    input  logic                          i_ready,
    output logic [clog2(FIFO_DEPTH):0]    o_level,
    output logic                          o_overflow
);

    logic [LATENCY-1:0] vp_q, vp_d;
    logic [DECIM_W-1:0] cnt_q, cnt_d;
    logic               overflow_q, overflow_d;
    logic [DECIM_W-1:0] neff;
    logic               in_vld, keep, wr, rd;
    logic               fifo_full, fifo_empty;

    // Effective factor: 0 behaves like 1.
    assign neff   = (i_decim == '0) ? DECIM_W'(1) : i_decim;
    assign in_vld = vp_q[LATENCY-1];
    assign keep   = in_vld && (cnt_q == '0);
    assign rd     = o_valid && i_ready;
    assign wr     = keep && (!fifo_full || rd);

    always_comb begin
        vp_d       = vp_q;
        cnt_d      = cnt_q;
        overflow_d = overflow_q;
        if (i_srst) begin
            vp_d       = '0;
            cnt_d      = '0;
            overflow_d = 1'b0;
        end else begin
            // The pipe shifts every cycle regardless of i_en, mirroring the filter stages.
            vp_d[0] = i_en;
            for (int k = 1; k < LATENCY; k++) begin
                vp_d[k] = vp_q[k-1];
            end
            // The >= compare (not ==) lets a count stranded above a newly lowered N wrap to 0.
            if (in_vld) begin
                cnt_d = (cnt_q >= neff - DECIM_W'(1)) ? '0 : cnt_q + DECIM_W'(1);
            end
            if (keep && !wr) overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            vp_q       <= '0;
            cnt_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            vp_q       <= vp_d;
            cnt_q      <= cnt_d;
            overflow_q <= overflow_d;
        end
    end

    fir_out_fifo #(
        .WIDTH (WW_DATA),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .i_rst     (i_rst),
        .i_srst    (i_srst),
        .i_wr      (wr),
        .i_wr_data (i_data),
        .i_rd      (rd),
        .o_rd_data (o_data),
        .o_level   (o_level),
        .o_full    (fifo_full),
        .o_empty   (fifo_empty)
    );

    assign o_valid    = !fifo_empty;
    assign o_overflow = overflow_q;

endmodule

// File: tb/tb_fir_decim_out.sv
// Testbench for fir_decim_out: table-driven decimation vectors plus
// hand-written sequences for FIFO full/overflow, sync clear and async reset.
// A scoreboard queue holds expected output samples, pushed when a sample that
// must be kept is driven and popped when the DUT hands one to the consumer.
module tb_fir_decim_out;
    import fir_pkg::*;

    localparam int WW    = 8;
    localparam int DW    = 4;
    localparam int DEPTH = 8;
    localparam int LAT   = 3;
    localparam int LW    = clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          i_rst, i_srst, i_en, i_ready;
    logic [DW-1:0] i_decim;
    logic [WW-1:0] i_data, o_data, drv_val;
    logic          o_valid, o_overflow;
    logic [LW-1:0] o_level;

    logic [WW-1:0] dpipe [LAT];
    logic [WW-1:0] sb_q [$];
    int n_checks = 0;
    int n_errors = 0;
    int n_reads  = 0;

    typedef struct {
        logic [DW-1:0] decim;
        int            n;
        logic          gap;
        logic [15:0]   keep_mask;
    } vec_t;
    vec_t vecs [6];

    always #5 clk = ~clk;

    // Filter model: the value strobed with i_en shows up on i_data LAT cycles later.
    always @(posedge clk) begin
        dpipe[0] <= drv_val;
        for (int k = 1; k < LAT; k++) dpipe[k] <= dpipe[k-1];
    end
    assign i_data = dpipe[LAT-1];

    fir_decim_out #(
        .WW_DATA    (WW),
        .LATENCY    (LAT),
        .DECIM_W    (DW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .i_rst      (i_rst),
        .i_srst     (i_srst),
        .i_en       (i_en),
        .i_decim    (i_decim),
        .i_data     (i_data),
        .o_data     (o_data),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_level    (o_level),
        .o_overflow (o_overflow)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard consumer: a transfer happens at the next rising edge.
    always @(negedge clk) begin
        if (!i_rst && o_valid && i_ready) begin
            n_reads++;
            check("sb_expected_available", 32'(sb_q.size() != 0), 1);
            if (sb_q.size() != 0) check("sb_data", o_data, sb_q.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic en, input logic [WW-1:0] val, input logic push);
        i_en    = en;
        drv_val = en ? val : 8'hEE;
        if (en && push) sb_q.push_back(val);
        tick();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1'b0, 8'h00, 1'b0);
    endtask

    task automatic do_srst();
        i_en   = 1'b0;
        i_srst = 1'b1;
        tick();
        i_srst = 1'b0;
    endtask

    task automatic drain(input string name, input int budget);
        int k;
        k = 0;
        i_ready = 1'b1;
        while (sb_q.size() != 0 && k < budget) begin
            tick();
            k++;
        end
        check(name, sb_q.size(), 0);
        idle(6);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WW-1:0] v1 [5];
        logic [15:0]   m;
        int            r0;
        int            max_lvl;

        vecs[0] = '{decim: 4'd3,  n: 9,  gap: 1'b0, keep_mask: 16'h0049};
        vecs[1] = '{decim: 4'd0,  n: 5,  gap: 1'b0, keep_mask: 16'h001F};
        vecs[2] = '{decim: 4'd1,  n: 5,  gap: 1'b0, keep_mask: 16'h001F};
        vecs[3] = '{decim: 4'd2,  n: 7,  gap: 1'b1, keep_mask: 16'h0055};
        vecs[4] = '{decim: 4'd4,  n: 9,  gap: 1'b0, keep_mask: 16'h0111};
        vecs[5] = '{decim: 4'd15, n: 16, gap: 1'b0, keep_mask: 16'h8001};

        i_rst = 1'b1; i_srst = 1'b0; i_en = 1'b0; i_ready = 1'b0;
        i_decim = 4'd1; drv_val = 8'hEE;
        tick(); tick();
        check("rst_valid",    o_valid,    0);
        check("rst_data",     o_data,     0);
        check("rst_level",    o_level,    0);
        check("rst_overflow", o_overflow, 0);
        i_rst = 1'b0;
        tick();

        // 1: five pulses at c=10..14, outputs at c=14..18.
        do_srst();
        i_decim = 4'd1; i_ready = 1'b1;
        v1 = '{8'h80, 8'hFF, 8'h01, 8'h7F, 8'h5A};
        max_lvl = 0;
        r0 = n_reads;
        for (int c = 0; c < 25; c++) begin
            check($sformatf("t1_valid_c%0d", c), o_valid, 32'(c >= 14 && c <= 18));
            if (int'(o_level) > max_lvl) max_lvl = int'(o_level);
            if (c >= 10 && c <= 14) drive(1'b1, v1[c-10], 1'b1);
            else                    drive(1'b0, 8'h00, 1'b0);
        end
        check("t1_max_level", max_lvl, 1);
        check("t1_overflow",  o_overflow, 0);
        check("t1_nreads",    n_reads - r0, 5);
        check("t1_sb_empty",  sb_q.size(), 0);

        // 2: decimation table.
        for (int r = 0; r < 6; r++) begin
            do_srst();
            i_decim = vecs[r].decim; i_ready = 1'b1;
            m  = vecs[r].keep_mask;
            r0 = n_reads;
            for (int i = 0; i < vecs[r].n; i++) begin
                drive(1'b1, 8'(r * 16 + i + 1), m[i]);
                if (vecs[r].gap) idle(1);
            end
            idle(4);
            drain($sformatf("t2_drain_row%0d", r), 40);
            check($sformatf("t2_nreads_row%0d", r), n_reads - r0, $countones(m));
        end

        // 2b: lowering N while cnt is above the new N-1 wraps without a keep.
        do_srst();
        i_decim = 4'd4; i_ready = 1'b1;
        r0 = n_reads;
        drive(1'b1, 8'hC0, 1'b1);
        drive(1'b1, 8'hC1, 1'b0);
        drive(1'b1, 8'hC2, 1'b0);
        idle(4);
        i_decim = 4'd2;
        drive(1'b1, 8'hC3, 1'b0);
        drive(1'b1, 8'hC4, 1'b1);
        drive(1'b1, 8'hC5, 1'b0);
        idle(4);
        drain("t2b_drain", 20);
        check("t2b_nreads", n_reads - r0, 2);

        // 4: full FIFO, read and kept write in the same cycle.
        do_srst();
        i_decim = 4'd1; i_ready = 1'b0;
        for (int i = 0; i < 8; i++) drive(1'b1, 8'(8'h21 + i), 1'b0);
        idle(4);
        check("t4_level_full", o_level, 8);
        drive(1'b1, 8'h29, 1'b0);
        idle(2);
        sb_q.push_back(8'h21);
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
        check("t4_level_kept", o_level,    8);
        check("t4_overflow",   o_overflow, 0);
        check("t4_head",       o_data,     8'h22);
        for (int i = 1; i < 9; i++) sb_q.push_back(8'(8'h21 + i));
        drain("t4_drain", 30);

        // 3: overflow on the 9th sample, sticky through draining.
        do_srst();
        i_decim = 4'd1; i_ready = 1'b0;
        for (int i = 1; i <= 8; i++) drive(1'b1, 8'(i), 1'b0);
        idle(4);
        check("t3_level8",      o_level,    8);
        check("t3_ovf_before",  o_overflow, 0);
        check("t3_head",        o_data,     1);
        drive(1'b1, 8'd9, 1'b0);
        idle(2);
        check("t3_ovf_not_yet", o_overflow, 0);
        idle(1);
        check("t3_ovf_set",     o_overflow, 1);
        drive(1'b1, 8'd10, 1'b0);
        idle(4);
        check("t3_level_still8", o_level,   8);
        check("t3_head_held",    o_data,    1);
        check("t3_valid_held",   o_valid,   1);
        for (int i = 1; i <= 8; i++) sb_q.push_back(8'(i));
        drain("t3_drain", 30);
        check("t3_ovf_sticky", o_overflow, 1);
        check("t3_level_empty", o_level,   0);

        // 5: sync clear with level=5, cnt=2 (overflow still set from 3).
        i_decim = 4'd4; i_ready = 1'b0;
        for (int i = 1; i <= 18; i++) drive(1'b1, 8'(i), 1'b0);
        idle(3);
        check("t5_level5",  o_level,    5);
        check("t5_pre_ovf", o_overflow, 1);
        do_srst();
        check("t5_level",    o_level,    0);
        check("t5_valid",    o_valid,    0);
        check("t5_overflow", o_overflow, 0);
        check("t5_data",     o_data,     0);
        i_ready = 1'b1;
        r0 = n_reads;
        drive(1'b1, 8'h77, 1'b1);
        idle(4);
        drain("t5_first_kept", 10);
        check("t5_nreads", n_reads - r0, 1);

        // 6: async reset between edges mid-burst, then latency after release.
        do_srst();
        i_decim = 4'd1; i_ready = 1'b0;
        for (int i = 0; i < 6; i++) drive(1'b1, 8'(8'h41 + i), 1'b0);
        check("t6_level_pre", o_level, 3);
        i_en = 1'b1; drv_val = 8'h47;
        #3;
        i_rst = 1'b1;
        #1;
        check("t6_async_valid", o_valid, 0);
        check("t6_async_level", o_level, 0);
        i_en = 1'b0; drv_val = 8'hEE;
        @(posedge clk);
        #4;
        i_rst = 1'b0;
        tick();
        for (int c = 0; c < 6; c++) begin
            check($sformatf("t6_valid_c%0d", c), o_valid, 32'(c >= 4));
            if (c == 4) check("t6_data", o_data, 8'h3C);
            drive(c == 0, 8'h3C, c == 0);
        end
        check("t6_level1",   o_level,    1);
        check("t6_overflow", o_overflow, 0);
        drain("t6_drain", 10);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fir_decim_out.md
Name: fir_decim_out

Overview:
Output stage placed directly downstream of the FIR filter.
- Tracks which filter output samples are valid by delaying the filter's i_en strobe through a model of the filter's pipeline latency.
- Keeps one sample in every N, where N is the decimation factor.
- Buffers kept samples in a small FIFO and presents them on a valid/ready stream to the next consumer (DMA/UART packer).

Parameters:
- WW_DATA, 8: sample width; equals the filter's WW_OUTPUT.
- LATENCY, 3: cycles from an i_en pulse to the matching sample at the filter's o_data (prod_d, sum_d and sum3_d stages).
- DECIM_W, 4: width of the runtime decimation factor.
- FIFO_DEPTH, 8: FIFO entries; must be a power of 2, minimum 2.

Ports:
- clk  in  1  clock, rising edge
- i_rst  in  1  asynchronous, active-high reset
- i_srst  in  1  synchronous clear, the same signal that drives the filter
- i_en  in  1  sample strobe, the same signal that drives the filter's i_en
- i_decim  in  DECIM_W  decimation factor N; 0 and 1 both mean keep every sample
- i_data  in  WW_DATA signed  the filter's o_data
- o_data  out  WW_DATA signed  FIFO head sample
- o_valid  out  1  o_data is valid
- i_ready  in  1  consumer accepts o_data
- o_level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
- o_overflow  out  1  sticky: a kept sample was dropped because the FIFO was full

Behaviour:
- i_rst (async, active-high): valid pipe, decimation counter, FIFO pointers and o_overflow go to 0. Outputs read o_valid=0, o_data=0, o_level=0, o_overflow=0. Applies mid-operation; FIFO contents are discarded.
- i_srst (sync, active-high, priority over all other activity in the same cycle): same clear as i_rst on the next edge.
- Valid pipe:
  - vp[0] <= i_en; vp[k] <= vp[k-1]. Shifts every clock, independent of i_en.
  - in_vld = vp[LATENCY-1]. When set, i_data is the filter's response to the sample strobed LATENCY cycles earlier.
- Decimation counter cnt (width DECIM_W), advances only on in_vld:
  - keep = in_vld && (cnt==0).
  - On in_vld: cnt <= (cnt >= Neff-1) ? 0 : cnt+1, where Neff = max(i_decim,1).
  - After i_rst/i_srst the first valid sample is always kept.
  - A change of i_decim mid-count takes effect immediately. If cnt already exceeds the new Neff-1, it wraps to 0 on the next in_vld.
- FIFO:
  - Synchronous, registered output, no fall-through.
  - wr = keep && (!full || rd); rd = o_valid && i_ready.
  - A sample written into an empty FIFO shows o_valid=1 on the cycle after the write. End-to-end, i_en to o_valid is LATENCY+1 cycles.
  - Simultaneous rd and wr when full: both succeed; level is unchanged.
  - Simultaneous rd and wr when level=1: o_data takes the new sample and o_valid stays 1.
  - keep while full with no rd: the sample is dropped and o_overflow <= 1. It stays 1 until i_rst or i_srst.
  - o_data holds its value while o_valid=1 and i_ready=0. It is don't-care but stable when o_valid=0.
  - Pointers wrap modulo FIFO_DEPTH; o_level ranges 0..FIFO_DEPTH.
- Width rule: no arithmetic on the sample; data is passed bit-exact.

Decomposition:
- Package fir_pkg holds:
  - WW_DATA default, LATENCY_FIR=3 and the FIFO_DEPTH default, shared with the filter instance.
  - A function clog2 for the o_level width.
- One sub-module, fir_out_fifo: parameterised synchronous FIFO (width, depth) with async reset, sync clear, level, full and empty.
- The valid pipe and decimation counter live in fir_decim_out.

Test Plan:
1. i_decim=1, i_ready=1; drive i_data equal to the filter response of 5 pulses at t=10..14 → o_valid high at t=14..18, o_data matches the sequence, o_level stays ≤1, o_overflow=0.
2. i_decim=3, 9 consecutive valid samples 1..9 → outputs 1, 4, 7 only; i_decim=0 gives the same result as i_decim=1.
3. i_ready=0, i_decim=1, 10 valid samples 1..10 → o_level=8, o_overflow=1 from the 9th sample, o_data=1. Then i_ready=1 → reads return 1..8 and o_overflow stays 1.
4. FIFO full, i_ready=1 in the same cycle a kept sample arrives → read and write both occur, o_level stays 8, no overflow.
5. i_srst asserted with o_level=5 and cnt=2 (i_decim=4) → next cycle o_level=0, o_valid=0, o_overflow=0; the next valid sample is kept.
6. Assert i_rst asynchronously mid-burst, between clock edges → o_valid and o_level drop to 0 immediately; after release, the i_en-to-o_valid latency is 4 cycles.
